// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// FSM encoding and default geometry.
package cache_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INDEX_W = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int TAG_W       = DEF_ADDR_W - DEF_INDEX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    WRITE  = 2'd3
  } state_e;

endpackage

// File: rtl/memoria.sv
// Dual-port RAM with a registered read address: q_o shows the word at the
// address captured on the previous edge, including any write made since.
module memoria #(
  parameter int ANCHO = 32,
  parameter int PROF  = 8
) (
  input  logic             clk_i,
  input  logic             wren_i,
  input  logic [PROF-1:0]  wraddr_i,
  input  logic [ANCHO-1:0] data_i,
  input  logic             rden_i,
  input  logic [PROF-1:0]  rdaddr_i,
  output logic [ANCHO-1:0] q_o
);

  logic [ANCHO-1:0] mem_q [2**PROF];
  logic [PROF-1:0]  rdaddr_q;

  // NOTE: storage arrays carry no reset so they map onto RAM macros; only
  // control state that must start known is reset.
  always_ff @(posedge clk_i) begin
    if (wren_i) mem_q[wraddr_i] <= data_i;
    if (rden_i) rdaddr_q <= rdaddr_i;
  end

  assign q_o = mem_q[rdaddr_q];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// single-word lines; tag/valid held locally, data held in a memoria instance.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ready_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int TAG_BITS = ADDR_W - INDEX_W;
  localparam int NLINES   = 2**INDEX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [NLINES-1:0]   valid_q;
  logic [TAG_BITS-1:0] tag_q [NLINES];

  logic [INDEX_W-1:0]  idx_q, rd_idx;
  logic [TAG_BITS-1:0] tag_in_q;
  logic                lookup_hit, flush, fill, arr_wren;
  logic [DATA_W-1:0]   arr_wdata, arr_q;

  assign idx_q      = addr_q[INDEX_W-1:0];
  assign tag_in_q   = addr_q[ADDR_W-1:INDEX_W];
  assign lookup_hit = valid_q[idx_q] && (tag_q[idx_q] == tag_in_q);

  memoria #(.ANCHO(DATA_W), .PROF(INDEX_W)) u_data (
    .clk_i    (clk_i),
    .wren_i   (arr_wren),
    .wraddr_i (idx_q),
    .data_i   (arr_wdata),
    .rden_i   (1'b1),
    .rdaddr_i (rd_idx),
    .q_o      (arr_q)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    hit_d       = hit_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    flush       = 1'b0;
    fill        = 1'b0;
    arr_wren    = 1'b0;
    arr_wdata   = mem_rdata_i;
    rd_idx      = idx_q;
    unique case (state_q)
      IDLE: begin
        // Present the incoming index now so the array word is ready in LOOKUP.
        rd_idx = cpu_addr_i[INDEX_W-1:0];
        if (flush_i) begin
          flush = 1'b1;
        end else if (cpu_req_i) begin
          addr_d  = cpu_addr_i;
          we_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = lookup_hit;
        if (lookup_hit) hit_cnt_d  = hit_cnt_q + 1'b1;
        else            miss_cnt_d = miss_cnt_q + 1'b1;
        if (we_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = WRITE;
        end else if (lookup_hit) begin
          cpu_rdata_d = arr_q;
          cpu_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          arr_wren    = 1'b1;
          fill        = 1'b1;
          cpu_rdata_d = mem_rdata_i;
          cpu_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack_i) begin
          // No-write-allocate: only a line that already holds this address is updated.
          arr_wren    = hit_q;
          arr_wdata   = wdata_q;
          cpu_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (flush)     valid_q        <= '0;
      else if (fill) valid_q[idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) tag_q[idx_q] <= tag_in_q;
  end

  assign cpu_ready_o = cpu_ready_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule
